// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request sequencer: issues word-aligned memory requests, tracks
// outstanding responses in order and drops responses from fetches killed by a branch.
module ibex_fetch_req_ctrl #(
   parameter int NUM_REQS = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         branch_addr_i,
   output logic                busy_o,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_clear_o,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_addr_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   input  logic                instr_gnt_i,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i
);

   localparam logic [NUM_REQS-1:0] ONE = {{(NUM_REQS-1){1'b0}}, 1'b1};

   logic [31:2]         r_fetchAddr;
   logic                r_pend;
   logic [31:2]         r_storedAddr;
   logic [NUM_REQS-1:0] r_outstanding;
   logic [NUM_REQS-1:0] r_discard;

   logic                w_newReq;
   logic                w_gnt;
   logic                w_rsp;
   logic [31:0]         w_instrAddr;
   logic [NUM_REQS-1:0] w_outShift;
   logic [NUM_REQS-1:0] w_discShift;
   logic [NUM_REQS-1:0] w_insert;
   logic [NUM_REQS-1:0] w_outNext;
   logic [NUM_REQS-1:0] w_discNext;

   // A branch may override a full FIFO, but never the outstanding-response limit.
   assign w_newReq    = req_i & (~(&fifo_busy_i) | branch_i) & ~r_outstanding[NUM_REQS-1];
   assign instr_req_o = ~rst_i & (w_newReq | r_pend);
   assign w_gnt       = instr_req_o & instr_gnt_i;
   assign w_rsp       = ~rst_i & instr_rvalid_i & r_outstanding[0];

   always_comb begin
      w_instrAddr = {r_fetchAddr, 2'b00};
      if (branch_i) begin
         w_instrAddr = {branch_addr_i[31:2], 2'b00};
      end else if (r_pend) begin
         w_instrAddr = {r_storedAddr, 2'b00};
      end
   end

   assign instr_addr_o = w_instrAddr;

   // Queue update: mark killed entries, retire the oldest, then append the new grant.
   always_comb begin
      w_outShift  = r_outstanding;
      w_discShift = r_discard | (branch_i ? r_outstanding : '0);
      if (w_rsp) begin
         w_outShift  = w_outShift >> 1;
         w_discShift = w_discShift >> 1;
      end
      w_insert = '0;
      if (w_gnt) begin
         w_insert = ~w_outShift & ((w_outShift << 1) | ONE);
      end
      w_outNext  = w_outShift | w_insert;
      w_discNext = w_discShift & ~w_insert & w_outNext;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetchAddr   <= '0;
         r_pend        <= 1'b0;
         r_storedAddr  <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         if (instr_req_o && !instr_gnt_i) begin
            r_pend       <= 1'b1;
            r_storedAddr <= w_instrAddr[31:2];
         end else if (w_gnt) begin
            r_pend <= 1'b0;
         end
         if (w_gnt) begin
            r_fetchAddr <= w_instrAddr[31:2] + 30'd1;
         end else if (branch_i) begin
            r_fetchAddr <= branch_addr_i[31:2];
         end
         r_outstanding <= w_outNext;
         r_discard     <= w_discNext;
      end
   end

   // A response with nothing outstanding is a memory protocol violation; it is dropped.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(instr_rvalid_i && !r_outstanding[0]))
            else $warning("rvalid received with no outstanding request");
      end
   end

   assign fifo_valid_o = w_rsp & ~r_discard[0] & ~branch_i;
   assign fifo_rdata_o = instr_rdata_i;
   assign fifo_err_o   = instr_err_i;
   assign fifo_addr_o  = branch_addr_i;
   assign fifo_clear_o = branch_i;
   assign busy_o       = ~rst_i & (r_outstanding[0] | r_pend);

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed self-checking bench for ibex_fetch_req_ctrl: every step drives inputs
// shortly after a rising edge and compares outputs against hand-computed values.
module tb_ibex_fetch_req_ctrl;

   logic        clk;
   logic        rst;
   logic        req;
   logic        branch;
   logic [31:0] branchAddr;
   logic        busy;
   logic [1:0]  fifoBusy;
   logic        fifoClear;
   logic        fifoValid;
   logic [31:0] fifoAddr;
   logic [31:0] fifoRdata;
   logic        fifoErr;
   logic        instrReq;
   logic        gnt;
   logic [31:0] instrAddr;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   int checks = 0;
   int errors = 0;

   ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_i          (req),
      .branch_i       (branch),
      .branch_addr_i  (branchAddr),
      .busy_o         (busy),
      .fifo_busy_i    (fifoBusy),
      .fifo_clear_o   (fifoClear),
      .fifo_valid_o   (fifoValid),
      .fifo_addr_o    (fifoAddr),
      .fifo_rdata_o   (fifoRdata),
      .fifo_err_o     (fifoErr),
      .instr_req_o    (instrReq),
      .instr_gnt_i    (gnt),
      .instr_addr_o   (instrAddr),
      .instr_rvalid_i (rvalid),
      .instr_rdata_i  (rdata),
      .instr_err_i    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs and let the combinational outputs settle.
   task automatic applyStimulus(input logic iReq, input logic iBranch, input logic [31:0] iBAddr,
                                input logic [1:0] iBusy, input logic iGnt, input logic iRvalid,
                                input logic [31:0] iRdata);
      req        = iReq;
      branch     = iBranch;
      branchAddr = iBAddr;
      fifoBusy   = iBusy;
      gnt        = iGnt;
      rvalid     = iRvalid;
      rdata      = iRdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
         else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      err = 1'b0;
      applyStimulus(0, 1, 32'h0000_0040, 2'b00, 0, 0, 32'h0);
      nextCycle();
      applyStimulus(0, 1, 32'h0000_0040, 2'b00, 0, 0, 32'h0);
      checkOutput("rst_req",   instrReq,  0);
      checkOutput("rst_busy",  busy,      0);
      checkOutput("rst_valid", fifoValid, 0);
      checkOutput("rst_clear", fifoClear, 1);
      nextCycle();

      // Sequential fetch with one-cycle response latency.
      rst = 1'b0;
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0);
      checkOutput("seq_req0",  instrReq,  1);
      checkOutput("seq_addr0", instrAddr, 32'h0000_0000);
      checkOutput("seq_busy0", busy,      0);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hAAAA_0000);
      checkOutput("seq_addr1",  instrAddr, 32'h0000_0004);
      checkOutput("seq_valid1", fifoValid, 1);
      checkOutput("seq_rdata1", fifoRdata, 32'hAAAA_0000);
      checkOutput("seq_busy1",  busy,      1);
      nextCycle();
      err = 1'b1;
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hAAAA_0004);
      checkOutput("seq_addr2",  instrAddr, 32'h0000_0008);
      checkOutput("seq_valid2", fifoValid, 1);
      checkOutput("seq_err2",   fifoErr,   1);
      nextCycle();
      err = 1'b0;
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'hAAAA_0008);
      checkOutput("seq_req3",   instrReq,  0);
      checkOutput("seq_valid3", fifoValid, 1);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 32'h0);
      checkOutput("seq_idle_busy", busy, 0);

      // Fill to two outstanding, then branch away and discard both.
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0);
      checkOutput("fill_addr0", instrAddr, 32'h0000_000C);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hBBBB_000C);
      checkOutput("fill_addr1",  instrAddr, 32'h0000_0010);
      checkOutput("fill_valid1", fifoValid, 1);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0);
      checkOutput("fill_addr2", instrAddr, 32'h0000_0014);
      checkOutput("fill_req2",  instrReq,  1);
      nextCycle();
      applyStimulus(1, 1, 32'h0000_0080, 2'b00, 0, 0, 32'h0);
      checkOutput("full_req",   instrReq,  0);
      checkOutput("full_clear", fifoClear, 1);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hDEAD_0010);
      checkOutput("disc_req0",   instrReq,  0);
      checkOutput("disc_valid0", fifoValid, 0);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hDEAD_0014);
      checkOutput("disc_valid1", fifoValid, 0);
      checkOutput("disc_addr",   instrAddr, 32'h0000_0080);
      checkOutput("disc_req1",   instrReq,  1);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'hCCCC_0080);
      checkOutput("tgt_valid", fifoValid, 1);
      checkOutput("tgt_rdata", fifoRdata, 32'hCCCC_0080);
      nextCycle();

      // Branch to a halfword target with nothing in flight.
      applyStimulus(1, 1, 32'h0000_0102, 2'b00, 1, 0, 32'h0);
      checkOutput("br_addr",  instrAddr, 32'h0000_0100);
      checkOutput("br_clear", fifoClear, 1);
      checkOutput("br_faddr", fifoAddr,  32'h0000_0102);
      checkOutput("br_req",   instrReq,  1);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 0, 1, 32'h1111_0100);
      checkOutput("br_next_addr", instrAddr, 32'h0000_0104);
      checkOutput("br_valid",     fifoValid, 1);
      nextCycle();

      // Grant withheld for three cycles, req dropped while pending.
      applyStimulus(1, 0, 32'h0, 2'b00, 0, 0, 32'h0);
      checkOutput("pend_req1",  instrReq,  1);
      checkOutput("pend_addr1", instrAddr, 32'h0000_0104);
      checkOutput("pend_busy",  busy,      1);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 32'h0);
      checkOutput("pend_req2",  instrReq,  1);
      checkOutput("pend_addr2", instrAddr, 32'h0000_0104);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 2'b00, 1, 0, 32'h0);
      checkOutput("pend_req3",  instrReq,  1);
      checkOutput("pend_addr3", instrAddr, 32'h0000_0104);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'h2222_0104);
      checkOutput("pend_after_req", instrReq,  0);
      checkOutput("pend_valid",     fifoValid, 1);
      nextCycle();

      // FIFO full throttles, except for a branch.
      applyStimulus(1, 0, 32'h0, 2'b11, 1, 0, 32'h0);
      checkOutput("fbusy_req", instrReq, 0);
      nextCycle();
      applyStimulus(1, 1, 32'h0000_0200, 2'b11, 0, 0, 32'h0);
      checkOutput("fbusy_br_req",  instrReq,  1);
      checkOutput("fbusy_br_addr", instrAddr, 32'h0000_0200);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b11, 1, 0, 32'h0);
      checkOutput("fbusy_pend_req",  instrReq,  1);
      checkOutput("fbusy_pend_addr", instrAddr, 32'h0000_0200);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0);
      checkOutput("fbusy_next_addr", instrAddr, 32'h0000_0204);
      nextCycle();

      // Reset with two outstanding; the late response must be ignored.
      rst = 1'b1;
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 32'h0);
      checkOutput("mid_rst_busy", busy, 0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'h3333_0200);
      checkOutput("post_rst_valid", fifoValid, 0);
      checkOutput("post_rst_busy",  busy,      0);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0);
      checkOutput("post_rst_addr", instrAddr, 32'h0000_0000);
      checkOutput("post_rst_req",  instrReq,  1);
      nextCycle();

      // Address wrap at the top of memory, with the older response discarded.
      applyStimulus(1, 1, 32'hFFFF_FFFE, 2'b00, 1, 0, 32'h0);
      checkOutput("wrap_br_addr", instrAddr, 32'hFFFF_FFFC);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'h4444_0000);
      checkOutput("wrap_full_req", instrReq,  0);
      checkOutput("wrap_disc",     fifoValid, 0);
      nextCycle();
      applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'h5555_FFFC);
      checkOutput("wrap_addr",  instrAddr, 32'h0000_0000);
      checkOutput("wrap_valid", fifoValid, 1);
      nextCycle();

      applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
